// File: rtl/mac_engine.sv
// ============================================================================
// mac_engine : parametrised multiply-accumulate engine with repeat-MAC mode
//              (T/P/accumulator datapath plus a 2-stage streaming MAC pipe).
//              Optional build macro: MAC_ENGINE_SAT_EN (saturating accumulate).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_engine #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 4,
  parameter int RPT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op,
  input  logic [DATA_W-1:0]     op_data,
  input  logic [SHIFT_W-1:0]    op_shift,
  input  logic [RPT_W-1:0]      rpt_count,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_a,
  input  logic [DATA_W-1:0]     s_b,
  output logic [DATA_W-1:0]     t_out,
  output logic [2*DATA_W-1:0]   p_out,
  output logic [ACC_W-1:0]      acc_out,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done
);

  localparam int c_PW = 2 * DATA_W;

  localparam logic [2:0] c_OP_LT     = 3'd1;
  localparam logic [2:0] c_OP_MPY    = 3'd2;
  localparam logic [2:0] c_OP_APAC   = 3'd3;
  localparam logic [2:0] c_OP_SPAC   = 3'd4;
  localparam logic [2:0] c_OP_ZAC    = 3'd5;
  localparam logic [2:0] c_OP_LAC    = 3'd6;
  localparam logic [2:0] c_OP_RPTMAC = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  generate
    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
      $error("mac_engine: ACC_W must be >= 2*DATA_W");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   t_q, t_d;
  logic [c_PW-1:0]     p_q, p_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                pv_q, pv_d;
  logic [RPT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;

  // One multiplier serves both MPY (T * op_data) and the stream (s_a * s_b).
  logic [DATA_W-1:0]   w_mul_a, w_mul_b;
  logic [c_PW-1:0]     w_prod;
  assign w_mul_a = (state_q == S_RUN) ? s_a : t_q;
  assign w_mul_b = (state_q == S_RUN) ? s_b : op_data;
  assign w_prod  = c_PW'($signed(w_mul_a)) * c_PW'($signed(w_mul_b));

  // Shared add/subtract of sign-extended P into the accumulator.
  logic                w_sub;
  logic [ACC_W-1:0]    w_p_ext, w_addend, w_sum, w_acc_res;
  logic                w_add_ovf;
  assign w_sub     = (state_q == S_IDLE) && op_valid && (op == c_OP_SPAC);
  assign w_p_ext   = ACC_W'($signed(p_q));
  assign w_addend  = w_sub ? ~w_p_ext : w_p_ext;
  assign w_sum     = acc_q + w_addend + ACC_W'(w_sub);
  assign w_add_ovf = (acc_q[ACC_W-1] == w_addend[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef MAC_ENGINE_SAT_EN
  localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // An overflow always leaves the result on the far side of acc's own sign.
  assign w_acc_res = w_add_ovf ? (acc_q[ACC_W-1] ? c_ACC_MIN : c_ACC_MAX) : w_sum;
`else
  assign w_acc_res = w_sum;
`endif

  logic [ACC_W-1:0]    w_op_ext, w_lac;
  assign w_op_ext = ACC_W'($signed(op_data));
  assign w_lac    = w_op_ext << op_shift;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    p_d     = p_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    pv_d    = pv_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          case (op)
            c_OP_LT:   t_d = op_data;
            c_OP_MPY:  p_d = w_prod;
            c_OP_APAC,
            c_OP_SPAC: begin
              acc_d = w_acc_res;
              if (w_add_ovf) ovf_d = 1'b1;
            end
            c_OP_ZAC: begin
              acc_d = '0;
              ovf_d = 1'b0;
            end
            c_OP_LAC: begin
              acc_d = w_lac;
              ovf_d = 1'b0;
            end
            c_OP_RPTMAC: begin
              cnt_d   = rpt_count;
              state_d = S_RUN;
            end
            default: ;
          endcase
        end
      end

      S_RUN: begin
        if (s_valid) begin
          p_d  = w_prod;
          pv_d = 1'b1;
          if (cnt_q == '0) state_d = S_DRAIN;
          else             cnt_d   = cnt_q - RPT_W'(1);
        end else begin
          pv_d = 1'b0;
        end
      end

      S_DRAIN: begin
        state_d = S_IDLE;
        pv_d    = 1'b0;
        done_d  = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // Stage 2: pv is only ever set in RUN/DRAIN, so it never collides with APAC/SPAC.
    if (pv_q) begin
      acc_d = w_acc_res;
      if (w_add_ovf) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      pv_q    <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      pv_q    <= pv_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign op_ready = (state_q == S_IDLE);
  assign s_ready  = (state_q == S_RUN);
  assign busy     = (state_q != S_IDLE);
  assign t_out    = t_q;
  assign p_out    = p_q;
  assign acc_out  = acc_q;
  assign ovf      = ovf_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_engine.sv
// ============================================================================
// tb_mac_engine : self-checking bench for mac_engine (DATA_W=16, ACC_W=32).
//                 Honours MAC_ENGINE_SAT_EN for the overflow expectations.
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_engine;

  localparam int DATA_W  = 16;
  localparam int ACC_W   = 32;
  localparam int SHIFT_W = 4;
  localparam int RPT_W   = 8;

  localparam logic [2:0] OP_NOP = 3'd0, OP_LT = 3'd1, OP_MPY = 3'd2, OP_APAC = 3'd3;
  localparam logic [2:0] OP_SPAC = 3'd4, OP_ZAC = 3'd5, OP_LAC = 3'd6, OP_RPT = 3'd7;

`ifdef MAC_ENGINE_SAT_EN
  localparam logic [31:0] c_ACC_POS_OVF = 32'h7FFF_FFFF;
  localparam logic [31:0] c_ACC_NEG_OVF = 32'h8000_0000;
`else
  localparam logic [31:0] c_ACC_POS_OVF = 32'hBFFD_8002;
  localparam logic [31:0] c_ACC_NEG_OVF = 32'h4001_FFFE;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                op_valid, op_ready;
  logic [2:0]          op;
  logic [DATA_W-1:0]   op_data;
  logic [SHIFT_W-1:0]  op_shift;
  logic [RPT_W-1:0]    rpt_count;
  logic                s_valid, s_ready;
  logic [DATA_W-1:0]   s_a, s_b;
  logic [DATA_W-1:0]   t_out;
  logic [2*DATA_W-1:0] p_out;
  logic [ACC_W-1:0]    acc_out;
  logic                ovf, busy, done;

  always #5 clk = ~clk;

  mac_engine #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W), .RPT_W(RPT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op(op), .op_data(op_data),
    .op_shift(op_shift), .rpt_count(rpt_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .t_out(t_out), .p_out(p_out), .acc_out(acc_out),
    .ovf(ovf), .busy(busy), .done(done)
  );

  typedef struct {
    logic [15:0] t;
    logic [31:0] p;
    logic [31:0] acc;
    logic        ovf;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] data;
    logic [3:0]  sh;
    exp_t        e;
  } vec_t;

  exp_t        sb_q[$];
  logic [31:0] prod_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input string name, input logic [2:0] o, input logic [15:0] d,
                              input logic [3:0] sh, input logic [15:0] t, input logic [31:0] p,
                              input logic [31:0] acc, input logic ov);
    vec_t v;
    v.name = name; v.op = o; v.data = d; v.sh = sh;
    v.e.t = t; v.e.p = p; v.e.acc = acc; v.e.ovf = ov;
    return v;
  endfunction

  function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return 32'(ia * ib);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".t"},        64'(t_out),    64'(0));
    chk({name, ".p"},        64'(p_out),    64'(0));
    chk({name, ".acc"},      64'(acc_out),  64'(0));
    chk({name, ".ovf"},      64'(ovf),      64'(0));
    chk({name, ".busy"},     64'(busy),     64'(0));
    chk({name, ".done"},     64'(done),     64'(0));
    chk({name, ".op_ready"}, 64'(op_ready), 64'(1));
    chk({name, ".s_ready"},  64'(s_ready),  64'(0));
  endtask

  task automatic check_exp(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({name, ".sb_empty"}, 64'(1), 64'(0));
      return;
    end
    e = sb_q.pop_front();
    chk({name, ".t"},   64'(t_out),   64'(e.t));
    chk({name, ".p"},   64'(p_out),   64'(e.p));
    chk({name, ".acc"}, 64'(acc_out), 64'(e.acc));
    chk({name, ".ovf"}, 64'(ovf),     64'(e.ovf));
  endtask

  task automatic do_op(input logic [2:0] o, input logic [15:0] d, input logic [3:0] sh);
    @(negedge clk);
    op = o; op_data = d; op_shift = sh; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op = OP_NOP;
  endtask

  // One stream pair; the expected product is queued at drive time and checked in P.
  task automatic drive_pair(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] t_hold);
    logic [31:0] e;
    @(negedge clk);
    s_valid = 1'b1; s_a = a; s_b = b;
    prod_q.push_back(smul(a, b));
    chk({name, ".s_ready"}, 64'(s_ready), 64'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    e = prod_q.pop_front();
    chk({name, ".p"},        64'(p_out),    64'(e));
    chk({name, ".op_ready"}, 64'(op_ready), 64'(0));
    chk({name, ".t"},        64'(t_out),    64'(t_hold));
  endtask

  initial begin
    vec_t vt[$];
    int   lat;

    reset = 1'b1; op_valid = 1'b0; op = OP_NOP; op_data = '0; op_shift = '0;
    rpt_count = '0; s_valid = 1'b0; s_a = '0; s_b = '0;

    vt.push_back(mk("lt3",      OP_LT,   16'h0003, 4'd0,  16'h0003, 32'h0000_0000, 32'h0000_0000, 1'b0));
    vt.push_back(mk("mpy_neg",  OP_MPY,  16'hFFFE, 4'd0,  16'h0003, 32'hFFFF_FFFA, 32'h0000_0000, 1'b0));
    vt.push_back(mk("apac1",    OP_APAC, 16'h0000, 4'd0,  16'h0003, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 1'b0));
    vt.push_back(mk("spac1",    OP_SPAC, 16'h0000, 4'd0,  16'h0003, 32'hFFFF_FFFA, 32'h0000_0000, 1'b0));
    vt.push_back(mk("lac_neg",  OP_LAC,  16'h8000, 4'd4,  16'h0003, 32'hFFFF_FFFA, 32'hFFF8_0000, 1'b0));
    vt.push_back(mk("nop",      OP_NOP,  16'h1234, 4'd3,  16'h0003, 32'hFFFF_FFFA, 32'hFFF8_0000, 1'b0));
    vt.push_back(mk("lt_max",   OP_LT,   16'h7FFF, 4'd0,  16'h7FFF, 32'hFFFF_FFFA, 32'hFFF8_0000, 1'b0));
    vt.push_back(mk("mpy_max",  OP_MPY,  16'h7FFF, 4'd0,  16'h7FFF, 32'h3FFF_0001, 32'hFFF8_0000, 1'b0));
    vt.push_back(mk("lac_s15",  OP_LAC,  16'h7FFF, 4'd15, 16'h7FFF, 32'h3FFF_0001, 32'h3FFF_8000, 1'b0));
    vt.push_back(mk("apac_ok",  OP_APAC, 16'h0000, 4'd0,  16'h7FFF, 32'h3FFF_0001, 32'h7FFE_8001, 1'b0));
    vt.push_back(mk("apac_ovf", OP_APAC, 16'h0000, 4'd0,  16'h7FFF, 32'h3FFF_0001, c_ACC_POS_OVF, 1'b1));
    vt.push_back(mk("ovf_stky", OP_NOP,  16'h0000, 4'd0,  16'h7FFF, 32'h3FFF_0001, c_ACC_POS_OVF, 1'b1));
    vt.push_back(mk("zac",      OP_ZAC,  16'h0000, 4'd0,  16'h7FFF, 32'h3FFF_0001, 32'h0000_0000, 1'b0));
    vt.push_back(mk("lac_min",  OP_LAC,  16'h8000, 4'd15, 16'h7FFF, 32'h3FFF_0001, 32'hC000_0000, 1'b0));
    vt.push_back(mk("spac_ok",  OP_SPAC, 16'h0000, 4'd0,  16'h7FFF, 32'h3FFF_0001, 32'h8000_FFFF, 1'b0));
    vt.push_back(mk("spac_ovf", OP_SPAC, 16'h0000, 4'd0,  16'h7FFF, 32'h3FFF_0001, c_ACC_NEG_OVF, 1'b1));
    vt.push_back(mk("lac_clr",  OP_LAC,  16'h0001, 4'd0,  16'h7FFF, 32'h3FFF_0001, 32'h0000_0001, 1'b0));
    vt.push_back(mk("lt_min",   OP_LT,   16'h8000, 4'd0,  16'h8000, 32'h3FFF_0001, 32'h0000_0001, 1'b0));
    vt.push_back(mk("mpy_mm",   OP_MPY,  16'h8000, 4'd0,  16'h8000, 32'h4000_0000, 32'h0000_0001, 1'b0));
    vt.push_back(mk("zac2",     OP_ZAC,  16'h0000, 4'd0,  16'h8000, 32'h4000_0000, 32'h0000_0000, 1'b0));
    vt.push_back(mk("lac10",    OP_LAC,  16'h000A, 4'd0,  16'h8000, 32'h4000_0000, 32'h0000_000A, 1'b0));

    // Reset state, then asynchronous reset from a non-zero state.
    repeat (2) @(posedge clk);
    #1 chk_zero("reset_init");
    @(negedge clk) reset = 1'b0;
    sb_q.push_back('{16'h1234, 32'h0, 32'h0, 1'b0});
    do_op(OP_LT, 16'h1234, 4'd0);  check_exp("pre_lt");
    sb_q.push_back('{16'h1234, 32'h0000_2468, 32'h0, 1'b0});
    do_op(OP_MPY, 16'h0002, 4'd0); check_exp("pre_mpy");
    sb_q.push_back('{16'h1234, 32'h0000_2468, 32'h0000_0F0F, 1'b0});
    do_op(OP_LAC, 16'h0F0F, 4'd0); check_exp("pre_lac");
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_zero("async_reset");
    @(posedge clk);
    #1 chk_zero("reset_held");
    @(negedge clk) reset = 1'b0;

    // Single-op vector table.
    for (int i = 0; i < vt.size(); i++) begin
      sb_q.push_back(vt[i].e);
      do_op(vt[i].op, vt[i].data, vt[i].sh);
      check_exp(vt[i].name);
      chk({vt[i].name, ".op_ready"}, 64'(op_ready), 64'(1));
    end

    // RPTMAC: 4 pairs onto acc=10, with a 2-cycle stall and LT held on the op port.
    @(negedge clk);
    op = OP_RPT; rpt_count = 8'd3; op_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rpt_start.busy",     64'(busy),     64'(1));
    chk("rpt_start.op_ready", 64'(op_ready), 64'(0));
    chk("rpt_start.s_ready",  64'(s_ready),  64'(1));
    op = OP_LT; op_data = 16'h5555;
    drive_pair("rpt_p1", 16'd1, 16'd2, 16'h8000);
    drive_pair("rpt_p2", 16'd3, 16'd4, 16'h8000);
    repeat (2) @(posedge clk);
    #1;
    chk("rpt_stall.acc", 64'(acc_out), 64'(24));
    chk("rpt_stall.t",   64'(t_out),   64'(16'h8000));
    drive_pair("rpt_p3", 16'hFFFF, 16'd5, 16'h8000);
    drive_pair("rpt_p4", 16'd2, 16'd2, 16'h8000);
    chk("rpt_drain.done",    64'(done),    64'(0));
    chk("rpt_drain.acc",     64'(acc_out), 64'(19));
    chk("rpt_drain.s_ready", 64'(s_ready), 64'(0));
    chk("rpt_drain.busy",    64'(busy),    64'(1));
    lat = 0;
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) lat = i;
    end
    chk("rpt_done.latency",  64'(lat),      64'(1));
    chk("rpt_done.acc",      64'(acc_out),  64'(23));
    chk("rpt_done.p",        64'(p_out),    64'(4));
    chk("rpt_done.t",        64'(t_out),    64'(16'h8000));
    chk("rpt_done.op_ready", 64'(op_ready), 64'(1));
    chk("rpt_done.ovf",      64'(ovf),      64'(0));
    @(posedge clk);
    #1;
    op_valid = 1'b0; op = OP_NOP;
    chk("rpt_after.done",     64'(done),     64'(0));
    chk("rpt_after.lt",       64'(t_out),    64'(16'h5555));
    chk("rpt_after.done_cnt", 64'(done_cnt), 64'(1));

    // Abort: reset partway through a 6-pair RPTMAC.
    @(negedge clk);
    op = OP_RPT; rpt_count = 8'd5; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op = OP_NOP;
    drive_pair("abort_p1", 16'd7, 16'd3, 16'h5555);
    drive_pair("abort_p2", 16'hFFFE, 16'hFFFE, 16'h5555);
    #2 reset = 1'b1;
    #1 chk_zero("abort_reset");
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("abort_idle");
    chk("abort.done_cnt", 64'(done_cnt), 64'(1));
    sb_q.push_back('{16'h0042, 32'h0, 32'h0, 1'b0});
    do_op(OP_LT, 16'h0042, 4'd0);
    check_exp("post_abort_lt");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
